// File: rtl/pe_nic_driver.sv
// pe_nic_driver
//   PE-side engine that drives one NIC's CPU register interface. It builds a
//   64-bit packet header from its own mesh position, polls the NIC output
//   status and writes the packet into the NIC output buffer. It also polls
//   the NIC input status, drains received packets and offers them on a
//   valid/ready port. TX and RX sequences are interleaved fairly.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   tx_valid/tx_ready          send request handshake
//   tx_dest_x/tx_dest_y        destination column/row
//   tx_payload                 32-bit payload
//   rx_valid/rx_ready/rx_data  received packet handshake and data
//   nic_addr, nic_d_in         NIC register address and write data
//   nic_d_out                  NIC read data, valid the cycle after a read
//   nic_en, nic_en_wr          NIC access strobe, 1 = write
//   tx_count, rx_count         wrapping packet counters
//
// State table
//   state     | meaning
//   S_IDLE    | choose TX or RX work, alternate when both are eligible
//   S_TX_POLL | read output status (2'b11)
//   S_TX_CHK  | output status on nic_d_out; full -> back off, else write
//   S_TX_WR   | write held packet to output buffer (2'b10)
//   S_RX_POLL | read input status (2'b01)
//   S_RX_CHK  | input status on nic_d_out; empty -> back off, else read
//   S_RX_RD   | read input buffer (2'b00)
//   S_RX_CAP  | capture nic_d_out into the rx holding register
module pe_nic_driver #(
  parameter int PACKET_WIDTH = 64,
  parameter int MY_X         = 0,
  parameter int MY_Y         = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [1:0]              tx_dest_x,
  input  logic [1:0]              tx_dest_y,
  input  logic [31:0]             tx_payload,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [PACKET_WIDTH-1:0] rx_data,
  output logic [1:0]              nic_addr,
  output logic [PACKET_WIDTH-1:0] nic_d_in,
  input  logic [PACKET_WIDTH-1:0] nic_d_out,
  output logic                    nic_en,
  output logic                    nic_en_wr,
  output logic [15:0]             tx_count,
  output logic [15:0]             rx_count
);

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam logic [1:0] POS_X = 2'(MY_X);
  localparam logic [1:0] POS_Y = 2'(MY_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_POLL,
    S_TX_CHK,
    S_TX_WR,
    S_RX_POLL,
    S_RX_CHK,
    S_RX_RD,
    S_RX_CAP
  } state_t;

  state_t state, state_nxt;

  logic                    tx_pending;
  logic                    rx_full;
  logic                    last_srv_tx;   // 1: TX served last, 0: RX served last
  logic [PACKET_WIDTH-1:0] tx_hold;
  logic                    tx_accept;

  logic        hdr_dx, hdr_dy;
  logic [1:0]  hdr_hx, hdr_hy;
  logic [63:0] tx_header;

  // Header fields from the request and this node's position.
  always_comb begin
    hdr_dx    = (tx_dest_x < POS_X);
    hdr_dy    = (tx_dest_y < POS_Y);
    hdr_hx    = hdr_dx ? (POS_X - tx_dest_x) : (tx_dest_x - POS_X);
    hdr_hy    = hdr_dy ? (POS_Y - tx_dest_y) : (tx_dest_y - POS_Y);
    tx_header = {1'b0, hdr_dx, hdr_dy, 5'd0,
                 2'd0, hdr_hx, 2'd0, hdr_hy,
                 2'd0, POS_X, 2'd0, POS_Y,
                 8'd0, tx_payload};
  end

  // Ready depends only on registered state, never on tx_valid.
  assign tx_ready  = ~tx_pending;
  assign tx_accept = tx_valid & ~tx_pending;
  assign rx_valid  = rx_full;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tx_pending && (rx_full || !last_srv_tx)) state_nxt = S_TX_POLL;
        else if (!rx_full)                           state_nxt = S_RX_POLL;
        else                                         state_nxt = S_IDLE;
      end
      S_TX_POLL: state_nxt = S_TX_CHK;
      S_TX_CHK:  state_nxt = nic_d_out[0] ? S_IDLE : S_TX_WR;
      S_TX_WR:   state_nxt = S_IDLE;
      S_RX_POLL: state_nxt = S_RX_CHK;
      S_RX_CHK:  state_nxt = nic_d_out[0] ? S_RX_RD : S_IDLE;
      S_RX_RD:   state_nxt = S_RX_CAP;
      S_RX_CAP:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NIC bus outputs; address and data are forced to zero when not strobed.
  always_comb begin
    nic_en    = 1'b0;
    nic_en_wr = 1'b0;
    nic_addr  = 2'b00;
    nic_d_in  = '0;
    case (state)
      S_TX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_OUT_STAT;
      end
      S_TX_WR: begin
        nic_en    = 1'b1;
        nic_en_wr = 1'b1;
        nic_addr  = ADDR_OUT_BUF;
        nic_d_in  = tx_hold;
      end
      S_RX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_STAT;
      end
      S_RX_RD: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_BUF;
      end
      default: ;
    endcase
  end

  // Holding registers, fairness flag and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_pending  <= 1'b0;
      tx_hold     <= '0;
      rx_full     <= 1'b0;
      rx_data     <= '0;
      last_srv_tx <= 1'b0;
      tx_count    <= 16'd0;
      rx_count    <= 16'd0;
    end else begin
      if (tx_accept) begin
        tx_pending <= 1'b1;
        tx_hold    <= tx_header;
      end
      if (rx_full && rx_ready) rx_full <= 1'b0;
      case (state)
        S_TX_CHK: if (nic_d_out[0]) last_srv_tx <= 1'b1;
        S_TX_WR: begin
          tx_pending  <= 1'b0;
          tx_count    <= tx_count + 16'd1;
          last_srv_tx <= 1'b1;
        end
        S_RX_CHK: if (!nic_d_out[0]) last_srv_tx <= 1'b0;
        S_RX_CAP: begin
          rx_data     <= nic_d_out;
          rx_full     <= 1'b1;
          rx_count    <= rx_count + 16'd1;
          last_srv_tx <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_nic_driver.sv
module tb_pe_nic_driver;
  localparam int MY_X = 1;
  localparam int MY_Y = 2;
  localparam byte POLL_T = 8'h54;
  localparam byte POLL_R = 8'h52;

  logic        clk;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  tx_dest_x, tx_dest_y;
  logic [31:0] tx_payload;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] rx_data;
  logic [1:0]  nic_addr;
  logic [63:0] nic_d_in;
  logic [63:0] nic_d_out = '0;
  logic        nic_en, nic_en_wr;
  logic [15:0] tx_count, rx_count;

  int tests_run = 0;
  int tests_failed = 0;

  pe_nic_driver #(.PACKET_WIDTH(64), .MY_X(MY_X), .MY_Y(MY_Y)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_payload(tx_payload),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
    .nic_en(nic_en), .nic_en_wr(nic_en_wr),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packet built straight from the field definitions.
  function automatic logic [63:0] ref_packet(logic [1:0] dx, logic [1:0] dy, logic [31:0] p);
    int ix, iy, hx, hy;
    logic [63:0] r;
    ix = int'(dx);
    iy = int'(dy);
    hx = (ix > MY_X) ? ix - MY_X : MY_X - ix;
    hy = (iy > MY_Y) ? iy - MY_Y : MY_Y - iy;
    r = '0;
    r[62] = (ix < MY_X);
    r[61] = (iy < MY_Y);
    r[55:52] = 4'(hx);
    r[51:48] = 4'(hy);
    r[47:44] = 4'(MY_X);
    r[43:40] = 4'(MY_Y);
    r[31:0] = p;
    return r;
  endfunction

  // NIC model and bus monitor. Queues here are written only by this process.
  logic [63:0] exp_q[$], wr_q[$], rx_sent_q[$], rx_got_q[$];
  byte         poll_q[$];
  logic [63:0] in_data [0:15];
  int          in_wr = 0, in_rd = 0;
  int          in_mode = 0;               // 1: random input status and data
  int unsigned out_full_pct = 0;
  int          out_full_until = 0;        // status polls below this index report full
  int          out_polls = 0, in_polls = 0, bus_err = 0;
  int          cyc = 0, accept_cyc = 0, write_cyc = 0;
  logic        mon_bit;
  logic [63:0] mon_d;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      exp_q.push_back(ref_packet(tx_dest_x, tx_dest_y, tx_payload));
      accept_cyc = cyc;
    end
    if (rx_valid && rx_ready) rx_got_q.push_back(rx_data);
    if (!nic_en) begin
      if (nic_en_wr || nic_addr != 2'b00 || nic_d_in != 64'd0) bus_err++;
    end else if (nic_en_wr) begin
      if (nic_addr == 2'b10) begin
        wr_q.push_back(nic_d_in);
        write_cyc = cyc;
      end else bus_err++;
    end else begin
      mon_d = {$urandom, $urandom};
      case (nic_addr)
        2'b11: begin
          mon_bit = (out_polls < out_full_until) || ($urandom_range(99) < out_full_pct);
          nic_d_out <= {mon_d[63:1], mon_bit};
          out_polls++;
          poll_q.push_back(POLL_T);
        end
        2'b01: begin
          mon_bit = (in_mode != 0) ? 1'($urandom_range(1)) : (in_rd != in_wr);
          nic_d_out <= {mon_d[63:1], mon_bit};
          in_polls++;
          poll_q.push_back(POLL_R);
        end
        2'b00: begin
          if (in_mode == 0) begin
            if (in_rd != in_wr) begin
              mon_d = in_data[in_rd % 16];
              in_rd++;
            end else mon_d = '0;
          end
          rx_sent_q.push_back(mon_d);
          nic_d_out <= mon_d;
        end
        default: bus_err++;
      endcase
    end
    cyc++;
  end

  task automatic send_one(input logic [1:0] dx, input logic [1:0] dy, input logic [31:0] p,
                          output bit ok);
    int n = 0;
    tx_dest_x = dx; tx_dest_y = dy; tx_payload = p; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    ok = (tx_ready === 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target, output bit ok);
    int n = 0;
    while (wr_q.size() < target && n < 500) begin @(negedge clk); n++; end
    ok = (wr_q.size() >= target);
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    tx_dest_x = '0; tx_dest_y = '0; tx_payload = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx_ready, rx_valid, nic_en, nic_en_wr, nic_addr} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, want 100000", {tx_ready, rx_valid, nic_en, nic_en_wr, nic_addr});
    end
    tests_run++;
    if (rx_data !== 64'd0 || nic_d_in !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_data: rx_data %h nic_d_in %h, want 0", rx_data, nic_d_in);
    end
    tests_run++;
    if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: tx %h rx %h, want 0", tx_count, rx_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_receive();
    int n = 0;
    int p0;
    rx_ready = 1'b0;
    in_data[in_wr % 16] = 64'h0123_4567_89AB_CDEF;
    in_wr++;
    while (rx_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 64'h0123_4567_89AB_CDEF) begin
      tests_failed++;
      $display("FAIL rx_data: valid %b data %h, want 1 0123456789abcdef", rx_valid, rx_data);
    end
    tests_run++;
    if (rx_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL rx_count: got %0d, want 1", rx_count);
    end
    p0 = in_polls;
    repeat (10) @(negedge clk);
    tests_run++;
    if (in_polls != p0 || rx_valid !== 1'b1 || rx_data !== 64'h0123_4567_89AB_CDEF) begin
      tests_failed++;
      $display("FAIL rx_hold: extra polls %0d valid %b data %h, want 0 1 0123456789abcdef",
               in_polls - p0, rx_valid, rx_data);
    end
  endtask

  task automatic test_basic_send();
    bit ok, ok2;
    int w0 = wr_q.size();
    send_one(2'd3, 2'd0, 32'hDEAD_BEEF, ok);
    wait_writes(w0 + 1, ok2);
    tests_run++;
    if (!(ok && ok2) || wr_q[w0] !== 64'h2022_1200_DEAD_BEEF) begin
      tests_failed++;
      $display("FAIL basic_send: got %h, want 2022_1200_deadbeef (ok %0b%0b)",
               ok2 ? wr_q[w0] : 64'd0, ok, ok2);
    end
    tests_run++;
    if (write_cyc - accept_cyc != 4) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d cycles, want 4", write_cyc - accept_cyc);
    end
    @(negedge clk);
    tests_run++;
    if (tx_count !== 16'd1 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_count: tx_count %0d tx_ready %b, want 1 1", tx_count, tx_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = 0, ready_bad = 0;
    int w0 = wr_q.size(), e0 = exp_q.size(), p0 = out_polls;
    out_full_until = out_polls + 5;
    send_one(2'($urandom_range(3)), 2'($urandom_range(3)), $urandom, ok);
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (wr_q.size() > w0) break;
      if (tx_ready !== 1'b0) ready_bad++;
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (!ok || wr_q.size() != w0 + 1 || exp_q.size() != e0 + 1) begin
      tests_failed++;
      $display("FAIL bp_writes: got %0d writes, want 1", wr_q.size() - w0);
    end else begin
      tests_run++;
      if (wr_q[w0] !== exp_q[e0]) begin
        tests_failed++;
        $display("FAIL bp_data: got %h, want %h", wr_q[w0], exp_q[e0]);
      end
    end
    tests_run++;
    if (out_polls - p0 != 6 || ready_bad != 0) begin
      tests_failed++;
      $display("FAIL bp_polls: polls %0d ready_high %0d, want 6 0", out_polls - p0, ready_bad);
    end
    tests_run++;
    if (tx_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d, want 2", tx_count);
    end
  endtask

  task automatic test_random_sends();
    bit ok, ok2;
    int w0, e0;
    for (int i = 0; i < 6; i++) begin
      w0 = wr_q.size(); e0 = exp_q.size();
      send_one(2'($urandom_range(3)), 2'($urandom_range(3)), $urandom, ok);
      wait_writes(w0 + 1, ok2);
      tests_run++;
      if (!(ok && ok2) || exp_q.size() != e0 + 1 || wr_q[w0] !== exp_q[e0]) begin
        tests_failed++;
        $display("FAIL rand_send[%0d]: got %h, want %h", i,
                 ok2 ? wr_q[w0] : 64'd0, (exp_q.size() > e0) ? exp_q[e0] : 64'd0);
      end
    end
    @(negedge clk);
    tests_run++;
    if (tx_count !== 16'd8) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d, want 8", tx_count);
    end
  endtask

  task automatic test_fairness();
    int pq0, pq_end, first_t, alt_err = 0, n_t = 0, n = 0, last, bad = 0;
    int w0 = wr_q.size(), e0 = exp_q.size();
    rx_ready = 1'b1;
    in_mode = 1; out_full_pct = 30;
    pq0 = poll_q.size();
    last = exp_q.size();
    tx_dest_x = 2'($urandom_range(3)); tx_dest_y = 2'($urandom_range(3)); tx_payload = $urandom;
    tx_valid = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (exp_q.size() != last) begin
        last = exp_q.size();
        tx_dest_x = 2'($urandom_range(3)); tx_dest_y = 2'($urandom_range(3)); tx_payload = $urandom;
      end
    end
    tx_valid = 1'b0;
    pq_end = poll_q.size();
    out_full_pct = 0; in_mode = 0;
    while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    first_t = -1;
    for (int i = pq0; i < pq_end; i++) begin
      if (first_t < 0 && poll_q[i] == POLL_T) first_t = i;
      if (first_t >= 0 && poll_q[i] == POLL_T) n_t++;
      if (first_t >= 0 && i > first_t && poll_q[i] == poll_q[i-1]) alt_err++;
    end
    tests_run++;
    if (alt_err != 0 || n_t < 20) begin
      tests_failed++;
      $display("FAIL fair_alternate: repeats %0d tx_seqs %0d, want 0 and >=20", alt_err, n_t);
    end
    tests_run++;
    if (wr_q.size() - w0 != exp_q.size() - e0) begin
      tests_failed++;
      $display("FAIL fair_tx_count: got %0d writes, want %0d", wr_q.size() - w0, exp_q.size() - e0);
    end else begin
      for (int k = 0; k < wr_q.size() - w0; k++) if (wr_q[w0+k] !== exp_q[e0+k]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL fair_tx_data: got %0d bad packets, want 0", bad);
      end
    end
    bad = 0;
    if (rx_got_q.size() == rx_sent_q.size())
      for (int k = 0; k < rx_got_q.size(); k++) if (rx_got_q[k] !== rx_sent_q[k]) bad++;
    tests_run++;
    if (rx_got_q.size() != rx_sent_q.size() || bad != 0 || rx_got_q.size() < 10) begin
      tests_failed++;
      $display("FAIL fair_rx_data: got %0d of %0d packets, %0d bad, want all and >=10",
               rx_got_q.size(), rx_sent_q.size(), bad);
    end
    tests_run++;
    if (tx_count !== 16'(wr_q.size()) || rx_count !== 16'(rx_sent_q.size())) begin
      tests_failed++;
      $display("FAIL fair_counts: tx %0d rx %0d, want %0d %0d",
               tx_count, rx_count, wr_q.size(), rx_sent_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    int n = 0, w0, e0;
    rx_ready = 1'b0;
    send_one(2'd0, 2'd3, 32'h1234_5678, ok);
    while (!(nic_en === 1'b1 && nic_en_wr === 1'b1) && n < 100) begin @(negedge clk); n++; end
    w0 = wr_q.size();
    reset = 1'b0;
    #1;
    tests_run++;
    if (!ok || n >= 100 || {tx_ready, rx_valid, nic_en, nic_en_wr, nic_addr} !== 6'b100000 ||
        nic_d_in !== 64'd0 || tx_count !== 16'd0 || rx_count !== 16'd0 || rx_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_tx_wr: ctrl %b d_in %h cnt %0d/%0d rx %h, want 100000 0 0/0 0",
               {tx_ready, rx_valid, nic_en, nic_en_wr, nic_addr}, nic_d_in, tx_count, rx_count, rx_data);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (wr_q.size() != w0) begin
      tests_failed++;
      $display("FAIL reset_discard: got %0d writes, want 0", wr_q.size() - w0);
    end
    in_data[in_wr % 16] = 64'hCAFE_F00D_0BAD_BEEF;
    in_wr++;
    n = 0;
    while (!(nic_en === 1'b1 && nic_en_wr === 1'b0 && nic_addr === 2'b00) && n < 100) begin
      @(negedge clk); n++;
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (n >= 100 || nic_en !== 1'b0 || nic_addr !== 2'b00 || rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_rx_rd: en %b addr %b rx_valid %b tx_ready %b, want 0 00 0 1",
               nic_en, nic_addr, rx_valid, tx_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (rx_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 64'hCAFE_F00D_0BAD_BEEF || rx_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL reset_rx_resume: valid %b data %h cnt %0d, want 1 cafef00d0badbeef 1",
               rx_valid, rx_data, rx_count);
    end
    repeat (3) @(negedge clk);
    w0 = wr_q.size(); e0 = exp_q.size();
    send_one(2'd1, 2'd2, 32'hA5A5_0001, ok);
    wait_writes(w0 + 1, ok2);
    @(negedge clk);
    tests_run++;
    if (!(ok && ok2) || wr_q[w0] !== exp_q[e0] || write_cyc - accept_cyc != 4 || tx_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL reset_tx_resume: data %h lat %0d cnt %0d, want %h 4 1",
               ok2 ? wr_q[w0] : 64'd0, write_cyc - accept_cyc, tx_count,
               (exp_q.size() > e0) ? exp_q[e0] : 64'd0);
    end
  endtask

  task automatic test_counter_wrap();
    bit ok, ok2;
    int w0;
    @(negedge clk);
    force dut.tx_count = 16'hFFFE;
    @(negedge clk);
    release dut.tx_count;
    @(negedge clk);
    w0 = wr_q.size();
    send_one(2'($urandom_range(3)), 2'($urandom_range(3)), $urandom, ok);
    wait_writes(w0 + 1, ok2);
    @(negedge clk);
    tests_run++;
    if (!(ok && ok2) || tx_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_ffff: got %h, want ffff", tx_count);
    end
    send_one(2'($urandom_range(3)), 2'($urandom_range(3)), $urandom, ok);
    wait_writes(w0 + 2, ok2);
    @(negedge clk);
    tests_run++;
    if (!(ok && ok2) || tx_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_zero: got %h, want 0000", tx_count);
    end
  endtask

  task automatic test_bus_rules();
    tests_run++;
    if (bus_err != 0) begin
      tests_failed++;
      $display("FAIL bus_rules: got %0d violations, want 0", bus_err);
    end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_basic_send();
    test_backpressure();
    test_random_sends();
    test_fairness();
    test_reset_mid();
    test_counter_wrap();
    test_bus_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
